disp_arb: RTL and testbench

DISP_ARB -- requirements
Module: disp_arb

---
 rtl/disp_arb.sv | 99 +++++++++
 tb/tb_disp_arb.sv | 138 +++++++++++++
 2 files changed

// File: rtl/disp_arb.sv
// Two-requester display arbiter: grants one owner at a time with a minimum tenure,
// forwards the owner's value pair to the seg driver and flags every change of owner.
module disp_arb #(
  parameter int HOLD_CYC = 50_000_000,
  parameter int W        = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0,
  input  logic [W-1:0] dat1_0,
  input  logic [W-1:0] dat2_0,
  input  logic         req1,
  input  logic [W-1:0] dat1_1,
  input  logic [W-1:0] dat2_1,
  output logic         gnt0,
  output logic         gnt1,
  output logic [W-1:0] dat1_out,
  output logic [W-1:0] dat2_out,
  output logic         sw_pulse
);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  localparam logic [25:0] HOLD_MAX = 26'(HOLD_CYC - 1);

  state_t         state_q, state_d;
  logic [25:0]    hold_cnt_q;
  logic           last_owner_q;
  logic           gnt0_q, gnt1_q, sw_pulse_q;
  logic [W-1:0]   dat1_q, dat2_q;
  logic           hold_done;
  logic           owner_change;

  assign hold_done    = (hold_cnt_q == HOLD_MAX);
  assign owner_change = (state_d != IDLE) && (state_d != state_q);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        // On a tie the requester that did not own the display last wins.
        if (req0 && req1)  state_d = last_owner_q ? OWN0 : OWN1;
        else if (req0)     state_d = OWN0;
        else if (req1)     state_d = OWN1;
      end
      OWN0: begin
        if (!req0)                  state_d = req1 ? OWN1 : IDLE;
        else if (req1 && hold_done) state_d = OWN1;
      end
      OWN1: begin
        if (!req1)                  state_d = req0 ? OWN0 : IDLE;
        else if (req0 && hold_done) state_d = OWN0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      gnt0_q       <= 1'b0;
      gnt1_q       <= 1'b0;
      sw_pulse_q   <= 1'b0;
      hold_cnt_q   <= '0;
      last_owner_q <= 1'b1;
      dat1_q       <= W'(12);
      dat2_q       <= W'(34);
    end else begin
      state_q    <= state_d;
      gnt0_q     <= (state_d == OWN0);
      gnt1_q     <= (state_d == OWN1);
      sw_pulse_q <= owner_change;

      if (owner_change) begin
        hold_cnt_q   <= '0;
        last_owner_q <= (state_d == OWN1);
      end else if (state_q != IDLE && !hold_done) begin
        hold_cnt_q <= hold_cnt_q + 26'd1;
      end

      // Data follows the next owner so values and grant move on the same edge;
      // in IDLE the last values stay up and the display never blanks.
      if (state_d == OWN0) begin
        dat1_q <= dat1_0;
        dat2_q <= dat2_0;
      end else if (state_d == OWN1) begin
        dat1_q <= dat1_1;
        dat2_q <= dat2_1;
      end
    end
  end

  assign gnt0     = gnt0_q;
  assign gnt1     = gnt1_q;
  assign sw_pulse = sw_pulse_q;
  assign dat1_out = dat1_q;
  assign dat2_out = dat2_q;

endmodule

// File: tb/tb_disp_arb.sv
// Directed bench for disp_arb with a short hold tenure of 4 cycles.
module tb_disp_arb;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         req0, req1;
  logic [W-1:0] dat1_0, dat2_0, dat1_1, dat2_1;
  logic         gnt0, gnt1, sw_pulse;
  logic [W-1:0] dat1_out, dat2_out;

  int n_checks = 0;
  int n_pass   = 0;

  disp_arb #(.HOLD_CYC(4), .W(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .req0     (req0),
    .dat1_0   (dat1_0),
    .dat2_0   (dat2_0),
    .req1     (req1),
    .dat1_1   (dat1_1),
    .dat2_1   (dat2_1),
    .gnt0     (gnt0),
    .gnt1     (gnt1),
    .dat1_out (dat1_out),
    .dat2_out (dat2_out),
    .sw_pulse (sw_pulse)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
  endtask

  // Advance one edge and sample shortly after it; grants must never overlap.
  task automatic step();
    @(posedge clk);
    #1;
    check("gnt_overlap", {31'd0, gnt0 & gnt1}, 32'd0);
  endtask

  task automatic expect_out(input string tag, input logic g0, input logic g1, input logic sw,
                            input logic [W-1:0] d1, input logic [W-1:0] d2);
    check({tag, "_gnt0"}, {31'd0, gnt0}, {31'd0, g0});
    check({tag, "_gnt1"}, {31'd0, gnt1}, {31'd0, g1});
    check({tag, "_sw"},   {31'd0, sw_pulse}, {31'd0, sw});
    check({tag, "_dat1"}, {24'd0, dat1_out}, {24'd0, d1});
    check({tag, "_dat2"}, {24'd0, dat2_out}, {24'd0, d2});
  endtask

  initial begin
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
    dat1_0 = 8'd0; dat2_0 = 8'd0; dat1_1 = 8'd0; dat2_1 = 8'd0;
    #2;

    // Reset state
    step(); step();
    expect_out("reset", 1'b0, 1'b0, 1'b0, 8'd12, 8'd34);

    // Single requester, then data tracking with one-cycle latency
    rst = 1'b0; req0 = 1'b1; dat1_0 = 8'd5; dat2_0 = 8'd6;
    step();
    expect_out("single", 1'b1, 1'b0, 1'b1, 8'd5, 8'd6);
    dat1_0 = 8'd7;
    step();
    expect_out("track", 1'b1, 1'b0, 1'b0, 8'd7, 8'd6);
    req0 = 1'b0;
    step();
    expect_out("rel0_idle", 1'b0, 1'b0, 1'b0, 8'd7, 8'd6);

    // Tie after a fresh reset: requester 0 first, then alternate every 4 cycles
    rst = 1'b1;
    step();
    rst = 1'b0;
    req0 = 1'b1; req1 = 1'b1;
    dat1_0 = 8'd5; dat2_0 = 8'd6; dat1_1 = 8'd8; dat2_1 = 8'd9;
    step();
    expect_out("tie_first", 1'b1, 1'b0, 1'b1, 8'd5, 8'd6);
    for (int i = 0; i < 3; i++) begin
      step();
      expect_out("tie_hold0", 1'b1, 1'b0, 1'b0, 8'd5, 8'd6);
    end
    step();
    expect_out("tie_sw1", 1'b0, 1'b1, 1'b1, 8'd8, 8'd9);
    for (int i = 0; i < 3; i++) begin
      step();
      expect_out("tie_hold1", 1'b0, 1'b1, 1'b0, 8'd8, 8'd9);
    end
    step();
    expect_out("tie_back0", 1'b1, 1'b0, 1'b1, 8'd5, 8'd6);

    // Early release by owner 0 at hold_cnt=1 hands over with no IDLE gap
    step();
    expect_out("early_hold", 1'b1, 1'b0, 1'b0, 8'd5, 8'd6);
    req0 = 1'b0;
    step();
    expect_out("early_rel", 1'b0, 1'b1, 1'b1, 8'd8, 8'd9);

    // Release to IDLE keeps the last requester-1 values on display
    dat1_1 = 8'd10; dat2_1 = 8'd11;
    step();
    expect_out("own1_track", 1'b0, 1'b1, 1'b0, 8'd10, 8'd11);
    req1 = 1'b0;
    step();
    expect_out("rel1_idle", 1'b0, 1'b0, 1'b0, 8'd10, 8'd11);
    dat1_1 = 8'd99; dat2_1 = 8'd98;
    step();
    expect_out("idle_hold", 1'b0, 1'b0, 1'b0, 8'd10, 8'd11);

    // Reset mid-tenure at hold_cnt=2 drops the grant without a pending switch
    req0 = 1'b1; dat1_0 = 8'd21; dat2_0 = 8'd22;
    step();
    expect_out("mid_enter", 1'b1, 1'b0, 1'b1, 8'd21, 8'd22);
    step(); step();
    check("mid_gnt0_h2", {31'd0, gnt0}, 32'd1);
    rst = 1'b1; req1 = 1'b1;
    step();
    expect_out("mid_rst", 1'b0, 1'b0, 1'b0, 8'd12, 8'd34);
    rst = 1'b0; req0 = 1'b0; dat1_1 = 8'd40; dat2_1 = 8'd41;
    step();
    expect_out("post_rst", 1'b0, 1'b1, 1'b1, 8'd40, 8'd41);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
